// File: rtl/x2050_mpxsched.sv
// Multiplexor routine scheduler: latches routine request strobes into a
// pending set, picks the lowest-numbered pending routine, and presents it
// to ROAR with a request/acknowledge handshake and an acknowledge timeout.
// Also tracks poll mode and keeps a saturating log event count.
module x2050_mpxsched #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ros_advance,
  input  logic [31:0] i_req,
  input  logic        i_resume_polling,
  input  logic        i_log,
  input  logic        i_roar_ack,
  output logic        o_roar_req,
  output logic [4:0]  o_routine,
  output logic [31:0] o_pending,
  output logic        o_polling,
  output logic        o_timeout,
  output logic [7:0]  o_log_count
);

  // b4, c4 and d6 never enter the pending set
  localparam logic [31:0] REQ_MASK = ~((32'd1 << 12) | (32'd1 << 20) | (32'd1 << 30));

  typedef enum logic [1:0] {IDLE, POLL, ISSUE, WAIT} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pending_reg, pending_sampled, pending_next;
  logic [31:0] grant_clear, first_hot, seen;
  logic [4:0]  winner, routine_reg, routine_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next, wait_inc;
  logic [7:0]  log_cnt_reg;
  logic        roar_req_reg, roar_req_next;
  logic        timeout_reg, timeout_next;

  // Priority chain: seen[gi] is high when any lower-numbered bit is pending,
  // so first_hot is the one-hot lowest pending bit.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_prio
      if (gi == 0) begin : g_first
        assign seen[gi] = 1'b0;
      end else begin : g_rest
        assign seen[gi] = seen[gi-1] | pending_reg[gi-1];
      end
      assign first_hot[gi] = pending_reg[gi] & ~seen[gi];
    end
  endgenerate

  // Encode the one-hot winner into a routine index
  always_comb begin
    winner = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (first_hot[i]) winner = winner | 5'(i);
    end
  end

  // Pending set: new (masked) requests only on ROS advance; a grant always clears its bit
  assign pending_sampled = i_ros_advance ? (pending_reg | (i_req & REQ_MASK)) : pending_reg;
  assign grant_clear     = (state_reg == ISSUE) ? first_hot : 32'd0;
  assign pending_next    = pending_sampled & ~grant_clear;
  assign wait_inc        = wait_cnt_reg + 8'd1;

  // Next-state and handshake decisions
  always_comb begin
    state_next    = state_reg;
    routine_next  = routine_reg;
    roar_req_next = roar_req_reg;
    timeout_next  = 1'b0;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pending_reg != 32'd0)  state_next = ISSUE;
        else if (i_resume_polling) state_next = POLL;
      end
      POLL: begin
        if (pending_reg != 32'd0) state_next = ISSUE;
      end
      ISSUE: begin
        if (pending_reg != 32'd0) begin
          routine_next  = winner;
          roar_req_next = 1'b1;
          wait_cnt_next = 8'd0;
          state_next    = WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        wait_cnt_next = wait_inc;
        if (i_roar_ack) begin
          // acknowledge beats a simultaneous timeout; a request sampled now counts
          roar_req_next = 1'b0;
          state_next    = (pending_sampled != 32'd0) ? ISSUE : IDLE;
        end else if (wait_inc == TIMEOUT) begin
          // routine is dropped, not re-pended
          roar_req_next = 1'b0;
          timeout_next  = 1'b1;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Scheduler state registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg    <= IDLE;
      pending_reg  <= 32'd0;
      routine_reg  <= 5'd0;
      roar_req_reg <= 1'b0;
      timeout_reg  <= 1'b0;
      wait_cnt_reg <= 8'd0;
    end else begin
      state_reg    <= state_next;
      pending_reg  <= pending_next;
      routine_reg  <= routine_next;
      roar_req_reg <= roar_req_next;
      timeout_reg  <= timeout_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // Saturating log event counter
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)                          log_cnt_reg <= 8'd0;
    else if (i_log && log_cnt_reg != 8'hFF) log_cnt_reg <= log_cnt_reg + 8'd1;
  end

  assign o_roar_req  = roar_req_reg;
  assign o_routine   = routine_reg;
  assign o_pending   = pending_reg;
  assign o_polling   = (state_reg == POLL);
  assign o_timeout   = timeout_reg;
  assign o_log_count = log_cnt_reg;

endmodule

// File: tb/tb_x2050_mpxsched.sv
// Self-checking bench for the multiplexor routine scheduler: directed
// scenarios plus randomized request sets checked against a set-based model.
module tb_x2050_mpxsched;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_ros_advance = 1'b0;
  logic [31:0] i_req = 32'd0;
  logic        i_resume_polling = 1'b0;
  logic        i_log = 1'b0;
  logic        i_roar_ack = 1'b0;
  logic        o_roar_req;
  logic [4:0]  o_routine;
  logic [31:0] o_pending;
  logic        o_polling;
  logic        o_timeout;
  logic [7:0]  o_log_count;

  int checks = 0;
  int failures = 0;

  x2050_mpxsched #(.TIMEOUT(8'd255)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_ros_advance(i_ros_advance),
    .i_req(i_req), .i_resume_polling(i_resume_polling), .i_log(i_log),
    .i_roar_ack(i_roar_ack), .o_roar_req(o_roar_req), .o_routine(o_routine),
    .o_pending(o_pending), .o_polling(o_polling), .o_timeout(o_timeout),
    .o_log_count(o_log_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic sample(input logic [31:0] r);
    i_ros_advance = 1'b1;
    i_req = r;
    tick();
    i_ros_advance = 1'b0;
    i_req = 32'd0;
  endtask

  // Wait (bounded) for a routine to be presented; returns cycles waited
  task automatic wait_req(output int n);
    n = 0;
    while (!o_roar_req && n < 12) begin
      tick();
      n++;
    end
    if (!o_roar_req) chk("wait_req_bound", o_roar_req, 1);
  endtask

  task automatic ack();
    i_roar_ack = 1'b1;
    tick();
    i_roar_ack = 1'b0;
    chk("ack_drop", o_roar_req, 0);
  endtask

  function automatic int lowest(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return 0;
  endfunction

  initial begin
    int n;
    int d;
    int idx;
    int lm;
    logic [31:0] mmask;
    logic [31:0] r;
    logic [31:0] expset;
    int order [3];

    mmask = 32'hFFFF_FFFF;
    mmask[12] = 1'b0;
    mmask[20] = 1'b0;
    mmask[30] = 1'b0;

    // Reset state
    #2;
    chk("rst_roar_req", o_roar_req, 0);
    chk("rst_routine", o_routine, 0);
    chk("rst_pending", o_pending, 0);
    chk("rst_polling", o_polling, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_log", o_log_count, 0);
    tick();
    tick();
    i_reset = 1'b1;
    tick();

    // Single request a1 with two-cycle latency
    sample(32'h2);
    chk("single_pending", o_pending, 32'h2);
    wait_req(n);
    chk("single_latency", n, 2);
    chk("single_routine", o_routine, 1);
    chk("single_pending_clr", o_pending, 0);
    ack();
    chk("single_idle_pending", o_pending, 0);
    tick();
    chk("single_idle_req", o_roar_req, 0);
    $display("txn single routine=1 done");

    // Priority order 0, 8, 31
    order[0] = 0; order[1] = 8; order[2] = 31;
    sample(32'h8000_0101);
    for (int k = 0; k < 3; k++) begin
      wait_req(n);
      chk("prio_routine", o_routine, order[k]);
      tick();
      chk("prio_hold_req", o_roar_req, 1);
      chk("prio_hold_routine", o_routine, order[k]);
      ack();
      $display("txn priority routine=%0d", order[k]);
    end
    tick();
    chk("prio_done", o_roar_req, 0);

    // Timeout on bit 17 after 255 unacknowledged WAIT cycles
    sample(32'd1 << 17);
    wait_req(n);
    chk("to_routine", o_routine, 17);
    n = 0;
    while (!o_timeout && n < 400) begin
      tick();
      n++;
    end
    chk("to_cycles", n, 255);
    chk("to_req_drop", o_roar_req, 0);
    tick();
    chk("to_pulse_once", o_timeout, 0);
    chk("to_no_repend", o_pending, 0);
    tick();
    chk("to_stays_idle", o_roar_req, 0);
    $display("txn timeout routine=17 cycles=%0d", n);

    // Acknowledge in the same cycle as the timeout boundary wins
    sample(32'd1 << 6);
    wait_req(n);
    repeat (254) tick();
    chk("ackwin_pre", o_timeout, 0);
    chk("ackwin_pre_req", o_roar_req, 1);
    ack();
    chk("ackwin_no_timeout", o_timeout, 0);
    $display("txn ack-at-timeout routine=6");

    // Ack ignored outside WAIT (held during ISSUE)
    sample(32'd1 << 4);
    tick();
    i_roar_ack = 1'b1;
    tick();
    i_roar_ack = 1'b0;
    chk("ackign_req", o_roar_req, 1);
    chk("ackign_routine", o_routine, 4);
    tick();
    chk("ackign_hold", o_roar_req, 1);
    ack();

    // Ack with simultaneous sample of bit 5, then re-pend of presented routine
    sample(32'd1 << 2);
    wait_req(n);
    chk("sim_first", o_routine, 2);
    i_roar_ack = 1'b1;
    i_ros_advance = 1'b1;
    i_req = 32'd1 << 5;
    tick();
    i_roar_ack = 1'b0;
    i_ros_advance = 1'b0;
    i_req = 32'd0;
    chk("sim_drop", o_roar_req, 0);
    chk("sim_pending", o_pending, 32'h20);
    tick();
    chk("sim_req", o_roar_req, 1);
    chk("sim_routine", o_routine, 5);
    sample(32'd1 << 5);
    chk("repend_pending", o_pending, 32'h20);
    ack();
    tick();
    chk("repend_req", o_roar_req, 1);
    chk("repend_routine", o_routine, 5);
    ack();
    tick();
    chk("repend_idle", o_roar_req, 0);
    $display("txn simultaneous/repend routine=5");

    // Masked bits and non-advance requests never pend
    sample((32'd1 << 12) | (32'd1 << 20) | (32'd1 << 30));
    chk("mask_pending", o_pending, 0);
    i_req = 32'd1 << 7;
    tick();
    i_req = 32'd0;
    chk("noadv_pending", o_pending, 0);
    tick();
    tick();
    chk("mask_idle", o_roar_req, 0);

    // Polling until a request arrives
    i_resume_polling = 1'b1;
    tick();
    i_resume_polling = 1'b0;
    chk("poll_on", o_polling, 1);
    tick();
    tick();
    chk("poll_stay", o_polling, 1);
    sample(32'd1 << 9);
    tick();
    chk("poll_off", o_polling, 0);
    wait_req(n);
    chk("poll_routine", o_routine, 9);
    ack();
    $display("txn poll routine=9");

    // Log counter: random strobes, then saturation over 300 pulses
    lm = 0;
    for (int k = 0; k < 40; k++) begin
      i_log = 1'($urandom_range(0, 1));
      if (i_log) lm++;
      tick();
    end
    i_log = 1'b0;
    chk("log_random", o_log_count, lm);
    i_log = 1'b1;
    for (int k = 0; k < 300; k++) begin
      tick();
      lm = (lm < 255) ? lm + 1 : 255;
      chk("log_sat", o_log_count, lm);
    end
    i_log = 1'b0;
    chk("log_final", o_log_count, 8'hFF);
    $display("txn log count=%0d", o_log_count);

    // Reset during WAIT
    sample(32'd1 << 2);
    wait_req(n);
    #2;
    i_reset = 1'b0;
    #1;
    chk("rw_roar_req", o_roar_req, 0);
    chk("rw_routine", o_routine, 0);
    chk("rw_pending", o_pending, 0);
    chk("rw_log", o_log_count, 0);
    tick();
    chk("rw_timeout", o_timeout, 0);
    chk("rw_polling", o_polling, 0);
    i_reset = 1'b1;
    sample(32'd1 << 3);
    wait_req(n);
    chk("rw_latency", n, 2);
    chk("rw_routine_after", o_routine, 3);
    ack();
    $display("txn reset-mid-wait then routine=3");

    // Randomized request sets against a set model
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        i_req = $urandom;
        tick();
        i_req = 32'd0;
        chk("rnd_noadv", o_pending, 0);
      end
      r = $urandom;
      sample(r);
      expset = r & mmask;
      chk("rnd_pending", o_pending, expset);
      while (expset != 32'd0) begin
        idx = lowest(expset);
        wait_req(n);
        chk("rnd_routine", o_routine, idx);
        d = $urandom_range(0, 4);
        repeat (d) begin
          tick();
          chk("rnd_hold", {o_roar_req, 26'd0, o_routine}, {1'b1, 26'd0, 5'(idx)});
        end
        ack();
        expset[idx] = 1'b0;
      end
      tick();
      tick();
      chk("rnd_done_req", o_roar_req, 0);
      chk("rnd_done_pending", o_pending, 0);
      $display("txn random it=%0d req=%08h", it, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
